// File: rtl/pixel_write_arbiter_if.sv
// Pixel-write bus between two writing clients and the VgaAdapter port.
// The arbiter uses the slave modport; the clients/bench use the master modport.
interface pixel_write_arbiter_if;
    logic       req0, req1;
    logic       we0, we1;
    logic [2:0] color0, color1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic       gnt0, gnt1;
    logic [2:0] color;
    logic [7:0] x;
    logic [6:0] y;
    logic       writeEn;
    logic       busy;
    logic [7:0] drop_cnt;

    modport slave (
        input  req0, req1, we0, we1, color0, color1, x0, x1, y0, y1,
        output gnt0, gnt1, color, x, y, writeEn, busy, drop_cnt
    );

    modport master (
        output req0, req1, we0, we1, color0, color1, x0, x1, y0, y1,
        input  gnt0, gnt1, color, x, y, writeEn, busy, drop_cnt
    );
endinterface

// File: rtl/pixel_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one VgaAdapter pixel-write port.
// Define PIXEL_ARB_CLIP_EN to drop (and count) writes outside X_MAX/Y_MAX.
module pixel_write_arbiter #(
    parameter int MAX_BURST = 64,
    parameter int X_MAX     = 159,
    parameter int Y_MAX     = 119
) (
    input  logic                 clk,
    input  logic                 rst,
    pixel_write_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);
    localparam logic [7:0] X_LIM     = 8'(X_MAX);
    localparam logic [6:0] Y_LIM     = 7'(Y_MAX);
`ifdef PIXEL_ARB_CLIP_EN
    localparam logic CLIP_EN = 1'b1;
`else
    localparam logic CLIP_EN = 1'b0;
`endif

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] burst_q, burst_d, burst_nxt;
    logic       accept, own_req, other_req;
    logic [2:0] sel_color;
    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic       in_range, clip_ok;
    logic       we_q;
    logic [2:0] color_q;
    logic [7:0] x_q;
    logic [6:0] y_q;

    // Owner-side view: a write counts only while its client holds the grant.
    always_comb begin
        accept    = 1'b0;
        own_req   = 1'b0;
        other_req = 1'b0;
        sel_color = bus.color0;
        sel_x     = bus.x0;
        sel_y     = bus.y0;
        if (state_q == OWN0) begin
            accept    = bus.we0;
            own_req   = bus.req0;
            other_req = bus.req1;
        end else if (state_q == OWN1) begin
            accept    = bus.we1;
            own_req   = bus.req1;
            other_req = bus.req0;
            sel_color = bus.color1;
            sel_x     = bus.x1;
            sel_y     = bus.y1;
        end
    end

    // Count including this cycle's write, so the limit-th write hands over at once.
    assign burst_nxt = (accept && burst_q != BURST_LIM) ? burst_q + 8'd1 : burst_q;
    assign in_range  = (sel_x <= X_LIM) && (sel_y <= Y_LIM);
    assign clip_ok   = in_range | ~CLIP_EN;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        burst_d = burst_nxt;
        unique case (state_q)
            IDLE: begin
                burst_d = '0;
                if (bus.req0 && bus.req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                    last_d  = ~last_q;
                end else if (bus.req0) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (bus.req1) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (!own_req || (burst_nxt == BURST_LIM && other_req))
                    state_d = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            color_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            we_q <= accept & clip_ok;
            if (accept) begin
                color_q <= sel_color;
                x_q     <= sel_x;
                y_q     <= sel_y;
            end
        end
    end

`ifdef PIXEL_ARB_CLIP_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drop_q <= '0;
        else if (accept && !in_range && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = '0;
`endif

    assign bus.gnt0    = (state_q == OWN0);
    assign bus.gnt1    = (state_q == OWN1);
    assign bus.busy    = (state_q != IDLE);
    assign bus.writeEn = we_q;
    assign bus.color   = color_q;
    assign bus.x       = x_q;
    assign bus.y       = y_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed and randomized bench for pixel_write_arbiter against a per-client
// ownership model; built with MAX_BURST=4 so hand-overs happen often.
module tb_pixel_write_arbiter;

    localparam int MAX_BURST = 4;
    localparam int X_MAX     = 159;
    localparam int Y_MAX     = 119;
`ifdef PIXEL_ARB_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pixel_write_arbiter_if bus ();

    pixel_write_arbiter #(.MAX_BURST(MAX_BURST), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic       req [2];
    logic       we  [2];
    logic [2:0] col [2];
    logic [7:0] xs  [2];
    logic [6:0] ys  [2];

    assign bus.req0 = req[0];   assign bus.req1 = req[1];
    assign bus.we0  = we[0];    assign bus.we1  = we[1];
    assign bus.color0 = col[0]; assign bus.color1 = col[1];
    assign bus.x0 = xs[0];      assign bus.x1 = xs[1];
    assign bus.y0 = ys[0];      assign bus.y1 = ys[1];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: who owns the port, whether we sit in the hand-over gap,
    // who was served last, and how many writes the current owner has made.
    int         m_owner;
    bit         m_gap;
    int         m_last;
    int         m_count;
    logic       exp_we;
    logic [2:0] exp_col;
    logic [7:0] exp_x;
    logic [6:0] exp_y;
    int         exp_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_gap    = 1'b0;
        m_last   = 1;
        m_count  = 0;
        exp_we   = 1'b0;
        exp_col  = '0;
        exp_x    = '0;
        exp_y    = '0;
        exp_drop = 0;
    endtask

    task automatic model_update();
        int  w;
        int  k;
        bit  inr;
        if (!rst) begin
            model_reset();
            return;
        end
        exp_we = 1'b0;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner < 0) begin
            w = -1;
            if (req[0] && req[1]) w = 1 - m_last;
            else if (req[0])      w = 0;
            else if (req[1])      w = 1;
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_count = 0;
            end
        end else begin
            k = m_owner;
            if (we[k]) begin
                if (m_count < MAX_BURST) m_count++;
                inr     = (int'(xs[k]) <= X_MAX) && (int'(ys[k]) <= Y_MAX);
                exp_we  = !CLIP || inr;
                exp_col = col[k];
                exp_x   = xs[k];
                exp_y   = ys[k];
                if (CLIP && !inr && exp_drop < 255) exp_drop++;
            end
            if (!req[k] || (m_count == MAX_BURST && req[1 - k])) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        check("gnt0",     32'(bus.gnt0),     32'(m_owner == 0));
        check("gnt1",     32'(bus.gnt1),     32'(m_owner == 1));
        check("busy",     32'(bus.busy),     32'(m_owner >= 0 || m_gap));
        check("writeEn",  32'(bus.writeEn),  32'(exp_we));
        check("color",    32'(bus.color),    32'(exp_col));
        check("x",        32'(bus.x),        32'(exp_x));
        check("y",        32'(bus.y),        32'(exp_y));
        check("drop_cnt", 32'(bus.drop_cnt), 32'(exp_drop));
        check("mutex",    32'(bus.gnt0 & bus.gnt1), 32'd0);
    endtask

    // One clock: model follows the edge, DUT outputs are sampled 1 ns later,
    // and the caller then drives the next inputs well before the next edge.
    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        int writes;
        bit seen_gap;

        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; col[i] = '0; xs[i] = '0; ys[i] = '0;
        end
        model_reset();
        repeat (2) cycle();
        rst = 1'b1;

        // Single client: five back-to-back writes x=10..14, y=20, color=3.
        req[0] = 1'b1;
        cycle();
        check("grant_latency", 32'(bus.gnt0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            we[0] = 1'b1; col[0] = 3'd3; xs[0] = 8'(10 + i); ys[0] = 7'd20;
            cycle();
            check("burst_x", 32'(bus.x), 32'(10 + i));
        end

        // Voluntary release, then the other client.
        we[0] = 1'b0; req[0] = 1'b0;
        cycle();
        check("release_gap", 32'({bus.busy, bus.gnt0, bus.writeEn}), 32'b100);
        cycle();
        check("release_idle", 32'(bus.busy), 32'd0);
        req[1] = 1'b1; col[1] = 3'd5; xs[1] = 8'd30; ys[1] = 7'd40;
        cycle();
        check("gnt1_latency", 32'(bus.gnt1), 32'd1);
        req[1] = 1'b0;
        cycle();
        cycle();

        // Ungranted write is ignored and not counted toward the burst.
        req[0] = 1'b1;
        cycle();
        we[1] = 1'b1;
        cycle();
        check("ungranted_we", 32'(bus.writeEn), 32'd0);

        // Forced hand-over after MAX_BURST writes from client 0.
        req[1] = 1'b1; we[0] = 1'b1;
        writes = 0; seen_gap = 1'b0;
        for (int i = 0; i < 20 && !seen_gap; i++) begin
            cycle();
            if (bus.writeEn) writes++;
            seen_gap = bus.busy && !bus.gnt0 && !bus.gnt1;
        end
        check("handover_gap_seen", 32'(seen_gap), 32'd1);
        check("handover_writes", 32'(writes), 32'(MAX_BURST));
        cycle();
        check("handover_idle", 32'(bus.busy), 32'd0);
        cycle();
        check("handover_gnt1", 32'(bus.gnt1), 32'd1);

        // Off-screen write from the new owner.
        xs[1] = 8'd160; ys[1] = 7'd5;
        cycle();
        check("clip_we", 32'(bus.writeEn), 32'(!CLIP));
        check("clip_drop", 32'(bus.drop_cnt), 32'(CLIP));
        if (!CLIP) check("clip_x", 32'(bus.x), 32'd160);
        xs[1] = 8'd50;
        cycle();

        // Asynchronous reset mid-burst, then tie goes to client 0.
        @(posedge clk);
        model_update();
        #3 rst = 1'b0;
        #1;
        check("rst_async", 32'({bus.gnt0, bus.gnt1, bus.busy, bus.writeEn, bus.color,
                                bus.x, bus.y, bus.drop_cnt}), 32'd0);
        model_reset();
        cycle();
        req[0] = 1'b1; req[1] = 1'b1; we[0] = 1'b0; we[1] = 1'b0;
        rst = 1'b1;
        cycle();
        check("rst_first_tie", 32'({bus.gnt0, bus.gnt1}), 32'b10);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                we[i]  = ($urandom_range(0, 3) != 0);
                col[i] = 3'($urandom_range(0, 7));
                xs[i]  = 8'($urandom_range(0, 175));
                ys[i]  = 7'($urandom_range(0, 127));
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
